// File: rtl/fifo_collector_if.sv
// Host-facing bundle for fifo_collector: capture stream, run control and indexed read port.
// The master drives capture and read requests; the slave returns read data and fill status.
interface fifo_collector_if #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned BITS  = 64
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic            en;
    logic [BITS-1:0] d;
    logic            clr;
    logic            rd_req;
    logic [AW-1:0]   rd_addr;
    logic            rd_valid;
    logic [BITS-1:0] rd_data;
    logic [AW:0]     count;
    logic            full;
    logic            overflow;

    modport master (
        output en, d, clr, rd_req, rd_addr,
        input  rd_valid, rd_data, count, full, overflow
    );

    modport slave (
        input  en, d, clr, rd_req, rd_addr,
        output rd_valid, rd_data, count, full, overflow
    );
endinterface

// File: rtl/fifo_collector.sv
// Captures the delay-buffer output stream into a DEPTH-entry bank in arrival order
// and serves indexed host reads with one cycle of latency.
module fifo_collector #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned BITS  = 64
) (
    input  logic            clk,
    input  logic            rst,
    fifo_collector_if.slave bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic {
        COLLECT = 1'b0,
        FULL    = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            full_q, full_d;
    logic            overflow_q, overflow_d;
    logic            rd_valid_q, rd_valid_d;
    logic [BITS-1:0] rd_data_q, rd_data_d;
    logic [BITS-1:0] mem_q [DEPTH];
    logic [BITS-1:0] mem_d [DEPTH];

    // Next-state: reads sample the pre-write bank, clr beats a same-cycle capture.
    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        rd_valid_d = bus.rd_req;
        rd_data_d  = rd_data_q;
        mem_d      = mem_q;

        if (bus.rd_req) begin
            rd_data_d = '0;
            if (32'(bus.rd_addr) < DEPTH) begin
                rd_data_d = mem_q[bus.rd_addr];
            end
        end

        if (bus.clr) begin
            state_d    = COLLECT;
            wr_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
        end else if (bus.en) begin
            case (state_q)
                COLLECT: begin
                    mem_d[wr_ptr_q] = bus.d;
                    count_d         = count_q + CW'(1);
                    // Explicit wrap keeps non-power-of-2 depths in range.
                    if (wr_ptr_q == AW'(DEPTH - 1)) begin
                        wr_ptr_d = '0;
                    end else begin
                        wr_ptr_d = wr_ptr_q + AW'(1);
                    end
                    if (count_q == CW'(DEPTH - 1)) begin
                        state_d = FULL;
                    end
                end
                FULL: begin
                    overflow_d = 1'b1;
                end
                default: begin
                    state_d = COLLECT;
                end
            endcase
        end

        full_d = (state_d == FULL);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= COLLECT;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            overflow_q <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            full_q     <= full_d;
            overflow_q <= overflow_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            mem_q      <= mem_d;
        end
    end

    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_data  = rd_data_q;
    assign bus.count    = count_q;
    assign bus.full     = full_q;
    assign bus.overflow = overflow_q;
endmodule

// File: tb/tb_fifo_collector.sv
// Directed plus randomized bench for fifo_collector against an append-list reference model.
module tb_fifo_collector;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned BITS  = 64;

    logic clk;
    logic rst;

    fifo_collector_if #(.DEPTH(DEPTH), .BITS(BITS)) bus ();

    fifo_collector #(.DEPTH(DEPTH), .BITS(BITS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: the bank is a list filled front to back since the last rst/clr.
    logic [BITS-1:0] m_mem [DEPTH];
    int              m_cnt;
    bit              m_ovf;
    bit              m_rv;
    logic [BITS-1:0] m_rd;

    task automatic chk(input string tag, input logic [BITS-1:0] obs, input logic [BITS-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply one clock edge to model and DUT, then compare every output.
    task automatic tick();
        if (rst) begin
            foreach (m_mem[i]) m_mem[i] = '0;
            m_cnt = 0;
            m_ovf = 0;
            m_rv  = 0;
            m_rd  = '0;
        end else begin
            m_rv = bus.rd_req;
            if (bus.rd_req) begin
                m_rd = (int'(bus.rd_addr) < int'(DEPTH)) ? m_mem[int'(bus.rd_addr)] : '0;
            end
            if (bus.clr) begin
                m_cnt = 0;
                m_ovf = 0;
            end else if (bus.en) begin
                if (m_cnt < int'(DEPTH)) begin
                    m_mem[m_cnt] = bus.d;
                    m_cnt++;
                end else begin
                    m_ovf = 1;
                end
            end
        end
        @(posedge clk);
        #1;
        chk("rd_valid", BITS'(bus.rd_valid), BITS'(m_rv));
        chk("rd_data",  bus.rd_data, m_rd);
        chk("count",    BITS'(bus.count), BITS'(m_cnt));
        chk("full",     BITS'(bus.full), BITS'(m_cnt == int'(DEPTH)));
        chk("overflow", BITS'(bus.overflow), BITS'(m_ovf));
    endtask

    task automatic idle();
        bus.en = 0; bus.clr = 0; bus.rd_req = 0;
    endtask

    task automatic write_word(input logic [BITS-1:0] w);
        idle(); bus.en = 1; bus.d = w; tick(); idle();
    endtask

    // Pulse a read, then an idle cycle so rd_valid must fall again.
    task automatic read_word(input int a, input logic [BITS-1:0] exp, input string tag);
        idle(); bus.rd_req = 1; bus.rd_addr = 3'(a); tick();
        chk(tag, bus.rd_data, exp);
        chk("rd_valid_pulse", BITS'(bus.rd_valid), BITS'(1));
        idle(); tick();
        chk("rd_valid_drop", BITS'(bus.rd_valid), BITS'(0));
    endtask

    initial begin
        rst = 1; bus.en = 0; bus.d = '0; bus.clr = 0; bus.rd_req = 0; bus.rd_addr = '0;
        foreach (m_mem[i]) m_mem[i] = '0;
        m_cnt = 0; m_ovf = 0; m_rv = 0; m_rd = '0;

        // Reset then fill 0x11..0x88.
        tick(); tick();
        chk("reset_count", BITS'(bus.count), BITS'(0));
        rst = 0;
        for (int i = 1; i <= 8; i++) write_word(BITS'(8'h11 * i));
        chk("fill_count", BITS'(bus.count), BITS'(8));
        chk("fill_full", BITS'(bus.full), BITS'(1));
        chk("fill_ovf", BITS'(bus.overflow), BITS'(0));
        for (int i = 0; i < 8; i++) read_word(i, BITS'(8'h11 * (i + 1)), "fill_read");

        // Overflow while full, then clr keeps storage.
        write_word(BITS'(16'hDEAD));
        chk("ovf_set", BITS'(bus.overflow), BITS'(1));
        chk("ovf_count", BITS'(bus.count), BITS'(8));
        read_word(0, BITS'(8'h11), "ovf_entry0");
        idle(); bus.clr = 1; tick(); idle();
        chk("clr_ovf", BITS'(bus.overflow), BITS'(0));
        chk("clr_count", BITS'(bus.count), BITS'(0));
        chk("clr_full", BITS'(bus.full), BITS'(0));
        read_word(3, BITS'(8'h44), "clr_keep3");

        // clr and en together: clr wins, next word lands in entry 0.
        for (int i = 0; i < 3; i++) write_word(BITS'({$urandom, $urandom}));
        idle(); bus.clr = 1; bus.en = 1; bus.d = BITS'(8'h99); tick(); idle();
        chk("clr_en_count", BITS'(bus.count), BITS'(0));
        write_word(BITS'(8'h55));
        read_word(0, BITS'(8'h55), "clr_en_entry0");

        // Read/write collision on entry 2 returns the old value.
        rst = 1; tick(); rst = 0;
        write_word(BITS'(8'hA0));
        write_word(BITS'(8'hA1));
        idle(); bus.en = 1; bus.d = BITS'(8'hAB); bus.rd_req = 1; bus.rd_addr = 3'd2; tick(); idle();
        chk("collide_old", bus.rd_data, BITS'(0));
        read_word(2, BITS'(8'hAB), "collide_new");

        // Back-to-back reads 7,6,5,4.
        for (int i = 3; i < 8; i++) write_word(BITS'(8'hB0 + i));
        for (int a = 7; a >= 4; a--) begin
            idle(); bus.rd_req = 1; bus.rd_addr = 3'(a); tick();
            chk("b2b_data", bus.rd_data, BITS'(8'hB0 + a));
        end
        idle(); tick();

        // Reset mid-operation aborts pending read and capture.
        rst = 1; tick(); rst = 0;
        for (int i = 0; i < 5; i++) write_word(BITS'({$urandom, $urandom}));
        rst = 1; bus.en = 1; bus.d = BITS'(8'h77); bus.rd_req = 1; bus.rd_addr = 3'd1; tick();
        rst = 0; idle();
        chk("rst_rv", BITS'(bus.rd_valid), BITS'(0));
        chk("rst_count", BITS'(bus.count), BITS'(0));
        chk("rst_full", BITS'(bus.full), BITS'(0));
        for (int i = 0; i < 8; i++) read_word(i, BITS'(0), "rst_zero");

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            rst          = ($urandom_range(0, 99) == 0);
            bus.clr      = ($urandom_range(0, 29) == 0);
            bus.en       = ($urandom_range(0, 2) != 0);
            bus.d        = BITS'({$urandom, $urandom});
            bus.rd_req   = ($urandom_range(0, 1) != 0);
            bus.rd_addr  = 3'($urandom_range(0, 7));
            tick();
        end
        rst = 0; idle(); tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
